scan_receiver: RTL and testbench

// Processor-side counterpart of the scanner: issues scan/transfer commands, waits for the

---
 rtl/scan_pkg.sv | 16 +
 rtl/scan_receiver_rx_buffer.sv | 48 ++++
 rtl/scan_receiver.sv | 128 ++++++++++++
 tb/tb_scan_receiver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/scan_pkg.sv
// Command codes and FSM state encoding shared between the scanner and its receiver.
package scan_pkg;

  localparam logic [1:0] CMD_NONE = 2'b00;
  localparam logic [1:0] CMD_SCAN = 2'b01;
  localparam logic [1:0] CMD_XFER = 2'b10;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_WAIT_RDY = 3'd2;
  localparam logic [2:0] ST_XFER_REQ = 3'd3;
  localparam logic [2:0] ST_RECEIVE  = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;
  localparam logic [2:0] ST_ERR      = 3'd6;

endpackage

// File: rtl/scan_receiver_rx_buffer.sv
// Frame byte store: one write port, registered read port, synchronous clear.
module rx_buffer #(
  parameter int NUM_BYTES = 10,
  parameter int ADDR_W    = 4
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [7:0]        wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [7:0]        rdData
);

  logic [7:0] mem [NUM_BYTES];
  logic [7:0] readByte;

  // Per-entry registers so the whole store can be cleared in one cycle.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_BYTES; gi++) begin : gEntry
      always_ff @(posedge clk) begin
        if (clear) begin
          mem[gi] <= 8'h00;
        end else if (wrEn && (wrAddr == ADDR_W'(gi))) begin
          mem[gi] <= wrData;
        end
      end
    end
  endgenerate

  // Addresses past the last entry fall through to zero.
  always_comb begin
    readByte = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (rdAddr == ADDR_W'(i)) readByte = mem[i];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      rdData <= 8'h00;
    end else begin
      rdData <= readByte;
    end
  end

endmodule

// File: rtl/scan_receiver.sv
// Issues scan/transfer commands to the scanner and deserialises its returned frame
// into a host-readable byte buffer.
module scan_receiver
  import scan_pkg::*;
#(
  parameter int NUM_BYTES = 10,
  parameter int ADDR_W    = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [1:0]        cmd,
  input  logic              scanReady,
  input  logic              scanStrobe,
  input  logic              scanData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [7:0]        rdData,
  output logic              busy,
  output logic              done,
  output logic              error
);

  logic [2:0]        state;
  logic [2:0]        stateNext;
  logic [2:0]        bitCnt;
  logic [ADDR_W-1:0] byteCnt;
  logic [7:0]        tmoCnt;
  logic [7:0]        shiftReg;
  logic [7:0]        assembled;
  logic              errorReg;
  logic              accept;
  logic              captureBit;
  logic              byteDone;
  logic              lastByte;
  logic              tmoHit;
  logic              timedState;

  assign accept     = (state == ST_IDLE) && start;
  assign captureBit = scanStrobe && ((state == ST_XFER_REQ) || (state == ST_RECEIVE));
  assign byteDone   = captureBit && (bitCnt == 3'd7);
  assign lastByte   = (byteCnt == ADDR_W'(NUM_BYTES - 1));
  // The counter would reach TIMEOUT on this edge.
  assign tmoHit     = (tmoCnt == 8'(TIMEOUT - 1));
  assign timedState = (state == ST_WAIT_RDY) || (state == ST_XFER_REQ) || (state == ST_RECEIVE);

  always_comb begin
    assembled = shiftReg;
    assembled[bitCnt] = scanData;
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:     if (start) stateNext = ST_REQ;
      ST_REQ:      stateNext = ST_WAIT_RDY;
      ST_WAIT_RDY: begin
        if (scanReady)   stateNext = ST_XFER_REQ;
        else if (tmoHit) stateNext = ST_ERR;
      end
      ST_XFER_REQ: begin
        if (scanStrobe)  stateNext = ST_RECEIVE;
        else if (tmoHit) stateNext = ST_ERR;
      end
      ST_RECEIVE: begin
        if (byteDone && lastByte)     stateNext = ST_DONE;
        else if (!scanStrobe && tmoHit) stateNext = ST_ERR;
      end
      ST_DONE:     stateNext = ST_IDLE;
      ST_ERR:      stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      bitCnt   <= 3'd0;
      byteCnt  <= '0;
      tmoCnt   <= 8'd0;
      shiftReg <= 8'h00;
      errorReg <= 1'b0;
    end else begin
      state <= stateNext;

      if ((stateNext != state) || captureBit || !timedState) begin
        tmoCnt <= 8'd0;
      end else begin
        tmoCnt <= tmoCnt + 8'd1;
      end

      if (accept) begin
        errorReg <= 1'b0;
      end else if (stateNext == ST_ERR) begin
        errorReg <= 1'b1;
      end

      if (accept) begin
        bitCnt  <= 3'd0;
        byteCnt <= '0;
      end else if (captureBit) begin
        shiftReg <= assembled;
        bitCnt   <= bitCnt + 3'd1;
        if (byteDone) byteCnt <= byteCnt + ADDR_W'(1);
      end
    end
  end

  rx_buffer #(
    .NUM_BYTES(NUM_BYTES),
    .ADDR_W   (ADDR_W)
  ) uBuffer (
    .clk   (clk),
    .clear (!rst),
    .wrEn  (byteDone),
    .wrAddr(byteCnt),
    .wrData(assembled),
    .rdAddr(rdAddr),
    .rdData(rdData)
  );

  assign cmd   = (state == ST_REQ)      ? CMD_SCAN :
                 (state == ST_XFER_REQ) ? CMD_XFER : CMD_NONE;
  assign busy  = (state != ST_IDLE);
  assign done  = (state == ST_DONE);
  assign error = errorReg;

endmodule

// File: tb/tb_scan_receiver.sv
// Directed-sequence bench with randomised frame data and a byte-level buffer model.
module tb_scan_receiver;

  localparam int NUM_BYTES = 10;
  localparam int ADDR_W    = 4;
  localparam int TIMEOUT   = 255;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        cmd;
  logic              scanReady = 1'b0;
  logic              scanStrobe = 1'b0;
  logic              scanData = 1'b0;
  logic [ADDR_W-1:0] rdAddr = '0;
  logic [7:0]        rdData;
  logic              busy;
  logic              done;
  logic              error;

  int nAsserts = 0;
  int nFail = 0;
  int doneCount = 0;

  logic [7:0] frameBytes [NUM_BYTES];
  logic [7:0] refBuf [16];

  scan_receiver #(
    .NUM_BYTES(NUM_BYTES),
    .ADDR_W   (ADDR_W),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cmd       (cmd),
    .scanReady (scanReady),
    .scanStrobe(scanStrobe),
    .scanData  (scanData),
    .rdAddr    (rdAddr),
    .rdData    (rdData),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) doneCount++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic readAll(input string tag);
    for (int a = 0; a < 16; a++) begin
      rdAddr = ADDR_W'(a);
      tick();
      check($sformatf("%s_rd%0d", tag, a), rdData, (a < NUM_BYTES) ? refBuf[a] : 8'h00);
    end
  endtask

  task automatic clearModel();
    for (int k = 0; k < 16; k++) refBuf[k] = 8'h00;
  endtask

  task automatic fillRandom();
    for (int k = 0; k < NUM_BYTES; k++) frameBytes[k] = 8'($urandom);
  endtask

  task automatic fillCount();
    for (int k = 0; k < NUM_BYTES; k++) frameBytes[k] = 8'(k);
  endtask

  // Scanner model: ready after readyDelay cycles, first strobe after xferDelay,
  // then nBits LSB-first bits separated by gap idle cycles.
  task automatic runFrame(input int readyDelay, input int xferDelay, input int gap,
                          input int nBits, input bit extraBit, input bit pokeStart);
    bit holdOk;
    $display("frame: ready %0d xfer %0d gap %0d bits %0d extra %0d", readyDelay, xferDelay, gap, nBits, extraBit);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("req_cmd", cmd, 2'b01);
    check("req_busy", busy, 1'b1);
    check("accept_err_clear", error, 1'b0);
    tick();
    check("wait_cmd", cmd, 2'b00);
    repeat (readyDelay - 2) tick();
    scanReady = 1'b1;
    tick();
    scanReady = 1'b0;
    check("xfer_cmd", cmd, 2'b10);
    holdOk = 1'b1;
    repeat (xferDelay) begin
      tick();
      if (cmd !== 2'b10) holdOk = 1'b0;
    end
    check("xfer_hold", holdOk, 1'b1);
    for (int i = 0; i < nBits; i++) begin
      scanStrobe = 1'b1;
      scanData = frameBytes[i / 8][i % 8];
      if (pokeStart && i == 40) start = 1'b1;
      tick();
      scanStrobe = 1'b0;
      start = 1'b0;
      if (i == 0) check("rx_cmd", cmd, 2'b00);
      if (i == nBits - 1 && extraBit) begin
        check("done_pulse", done, 1'b1);
        scanStrobe = 1'b1;
        scanData = 1'($urandom);
        tick();
        scanStrobe = 1'b0;
      end
      repeat (gap) tick();
    end
    for (int k = 0; k < nBits / 8 && k < NUM_BYTES; k++) refBuf[k] = frameBytes[k];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clearModel();

    // Power-on reset
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    check("por_cmd", cmd, 2'b00);
    check("por_busy", busy, 1'b0);
    check("por_error", error, 1'b0);
    readAll("por");

    // Nominal frame, bytes 0..9
    fillCount();
    doneCount = 0;
    runFrame(8, 3, 0, NUM_BYTES * 8, 1'b0, 1'b0);
    repeat (3) tick();
    check("nom_busy", busy, 1'b0);
    check("nom_done_count", doneCount, 1);
    check("nom_error", error, 1'b0);
    readAll("nom");

    // Reset mid-RECEIVE
    fillRandom();
    runFrame(8, 1, 0, 20, 1'b0, 1'b0);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    clearModel();
    check("rst_cmd", cmd, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_error", error, 1'b0);
    readAll("rst");

    // Ready never arrives
    doneCount = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tmo_req_cmd", cmd, 2'b01);
    tick();
    check("tmo_wait_cmd", cmd, 2'b00);
    repeat (TIMEOUT - 1) tick();
    check("tmo_pre_error", error, 1'b0);
    check("tmo_pre_busy", busy, 1'b1);
    tick();
    check("tmo_error", error, 1'b1);
    tick();
    check("tmo_idle", busy, 1'b0);
    check("tmo_done_count", doneCount, 0);
    check("tmo_sticky", error, 1'b1);

    // Restart after error with a good scanner
    fillRandom();
    doneCount = 0;
    runFrame(8, 2, 1, NUM_BYTES * 8, 1'b0, 1'b0);
    repeat (3) tick();
    check("clr_busy", busy, 1'b0);
    check("clr_done_count", doneCount, 1);
    check("clr_error", error, 1'b0);
    readAll("clr");

    // Mid-frame stall after 37 bits, from a cleared buffer
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    clearModel();
    fillRandom();
    doneCount = 0;
    runFrame(8, 2, 0, 37, 1'b0, 1'b0);
    repeat (TIMEOUT + 3) tick();
    check("stall_error", error, 1'b1);
    check("stall_busy", busy, 1'b0);
    check("stall_done_count", doneCount, 0);
    readAll("stall");

    // Gapped strobes, trailing extra bit, start poked while busy
    fillCount();
    doneCount = 0;
    runFrame(8, 3, 2, NUM_BYTES * 8, 1'b1, 1'b1);
    repeat (3) tick();
    check("gap_busy", busy, 1'b0);
    check("gap_cmd", cmd, 2'b00);
    check("gap_done_count", doneCount, 1);
    check("gap_error", error, 1'b0);
    readAll("gap");

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
